// File: rtl/axis_frame_source_pkg.sv
// Shared types and LFSR helpers for the AXI-Stream frame source.
// Package name is axis_src_pkg; both RTL modules import it.
package axis_src_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Galois taps 32,22,2,1 for a right-shifting register
  localparam logic [31:0] LFSR_MASK         = 32'h8020_0003;
  localparam logic [31:0] LFSR_DEFAULT_SEED = 32'h0000_0001;

  function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_MASK : 32'h0);
  endfunction

endpackage

// File: rtl/axis_frame_source_if.sv
// AXI-Stream beat channel between the frame source and its sink.
interface axis_frame_source_if #(
  parameter int STREAM_WIDTH = 32
);
  logic [STREAM_WIDTH-1:0] TDATA;
  logic                    TVALID;
  logic                    TLAST;
  logic                    TREADY;

  modport master (output TDATA, output TVALID, output TLAST, input TREADY);
  modport slave  (input TDATA, input TVALID, input TLAST, output TREADY);
endinterface

// File: rtl/axis_frame_source_lfsr.sv
// 32-bit Galois LFSR payload generator. A zero seed is replaced by the
// default seed so the register can never lock up in the all-zero state.
module axis_lfsr32
  import axis_src_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [31:0]      seed,
  input  logic             advance,
  output logic [OUT_W-1:0] value
);

  logic [31:0] lfsr_q;

  // Seed load wins over advance; the two are never requested together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_DEFAULT_SEED;
    end else if (load) begin
      lfsr_q <= (seed == 32'h0) ? LFSR_DEFAULT_SEED : seed;
    end else if (advance) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign value = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/axis_frame_source.sv
// AXI-Stream master emitting frames of LFSR payload beats, TLAST on the
// final beat. Optional macro AXIS_GOLDEN_MAX_EN adds golden_max /
// golden_valid, the largest payload of the last completed frame.
module axis_frame_source
  import axis_src_pkg::*;
#(
  parameter int STREAM_WIDTH = 32,
  parameter int LEN_W        = 16,
  parameter int DATA_BITS    = 16
) (
  input  logic                 ACLK,
  input  logic                 ARESET_n,
  input  logic                 start,
  input  logic [LEN_W-1:0]     frame_len,
  input  logic                 seed_load,
  input  logic [31:0]          seed,
  input  logic                 pause,
  output logic                 busy,
  output logic                 done,
`ifdef AXIS_GOLDEN_MAX_EN
  output logic [DATA_BITS-1:0] golden_max,
  output logic                 golden_valid,
`endif
  axis_frame_source_if.master  axis
);

  state_t               state_q, state_d;
  logic [LEN_W-1:0]     remaining_q, remaining_d;
  logic                 tvalid_q, tvalid_d;
  logic                 tlast_q, tlast_d;
  logic [DATA_BITS-1:0] payload;
  logic                 hs;
  logic                 accept;
  logic                 lfsr_load;

  assign hs        = tvalid_q && axis.TREADY;
  assign accept    = (state_q == IDLE) && start && (frame_len != '0);
  assign lfsr_load = (state_q == IDLE) && seed_load;

  axis_lfsr32 #(.OUT_W(DATA_BITS)) u_lfsr (
    .clk     (ACLK),
    .rst_n   (ARESET_n),
    .load    (lfsr_load),
    .seed    (seed),
    .advance (hs),
    .value   (payload)
  );

  // TDATA follows the LFSR, which only moves on a handshake, so a stalled
  // beat stays frozen; it reads zero whenever no beat is offered.
  assign axis.TDATA  = tvalid_q ? STREAM_WIDTH'(payload) : '0;
  assign axis.TVALID = tvalid_q;
  assign axis.TLAST  = tlast_q;
  assign busy        = (state_q == SEND);
  assign done        = (state_q == FIN);

  // State and beat-control registers.
  always_ff @(posedge ACLK or negedge ARESET_n) begin
    if (!ARESET_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
    end
  end

  // Next-state and beat launch; remaining counts beats not yet handshaked,
  // including the one currently offered.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          // First beat is launched in the same edge as the start is taken
          state_d     = SEND;
          remaining_d = frame_len;
          tvalid_d    = !pause;
          tlast_d     = !pause && (frame_len == LEN_W'(1));
        end
      end
      SEND: begin
        if (tvalid_q) begin
          if (axis.TREADY) begin
            remaining_d = remaining_q - LEN_W'(1);
            if (tlast_q) begin
              tvalid_d = 1'b0;
              tlast_d  = 1'b0;
              state_d  = FIN;
            end else if (!pause) begin
              tvalid_d = 1'b1;
              tlast_d  = (remaining_q == LEN_W'(2));
            end else begin
              tvalid_d = 1'b0;
              tlast_d  = 1'b0;
            end
          end
        end else if (!pause) begin
          tvalid_d = 1'b1;
          tlast_d  = (remaining_q == LEN_W'(1));
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef AXIS_GOLDEN_MAX_EN
  logic [DATA_BITS-1:0] run_max_q;
  logic [DATA_BITS-1:0] beat_max;

  assign beat_max     = (payload > run_max_q) ? payload : run_max_q;
  assign golden_valid = done;

  // Running max of accepted payloads; published on the TLAST handshake so
  // it is stable while golden_valid is high.
  always_ff @(posedge ACLK or negedge ARESET_n) begin
    if (!ARESET_n) begin
      run_max_q  <= '0;
      golden_max <= '0;
    end else if (accept) begin
      run_max_q <= '0;
    end else if (hs) begin
      run_max_q <= beat_max;
      if (tlast_q) begin
        golden_max <= beat_max;
      end
    end
  end
`else
  // Golden-max tracking is not built in this configuration.
`endif

endmodule

// File: tb/tb_axis_frame_source.sv
// Directed bench for axis_frame_source: single/multi-beat frames,
// backpressure, pause, ignored requests, seed handling and async reset.
module tb_axis_frame_source;

  logic        ACLK;
  logic        ARESET_n;
  logic        start;
  logic [15:0] frame_len;
  logic        seed_load;
  logic [31:0] seed;
  logic        pause;
  logic        busy;
  logic        done;
`ifdef AXIS_GOLDEN_MAX_EN
  logic [15:0] golden_max;
  logic        golden_valid;
`endif

  axis_frame_source_if #(.STREAM_WIDTH(32)) axis_bus ();

  axis_frame_source #(
    .STREAM_WIDTH(32),
    .LEN_W(16),
    .DATA_BITS(16)
  ) dut (
    .ACLK         (ACLK),
    .ARESET_n     (ARESET_n),
    .start        (start),
    .frame_len    (frame_len),
    .seed_load    (seed_load),
    .seed         (seed),
    .pause        (pause),
    .busy         (busy),
    .done         (done),
`ifdef AXIS_GOLDEN_MAX_EN
    .golden_max   (golden_max),
    .golden_valid (golden_valid),
`endif
    .axis         (axis_bus.master)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_errors = 0;
  int hs_cnt   = 0;
  int done_cnt = 0;

  always @(posedge ACLK) begin
    if (ARESET_n && axis_bus.TVALID && axis_bus.TREADY) hs_cnt++;
    if (ARESET_n && done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic launch(input logic [15:0] len, input logic ld, input logic [31:0] sd);
    start     = 1'b1;
    frame_len = len;
    seed_load = ld;
    seed      = sd;
    tick();
    start     = 1'b0;
    seed_load = 1'b0;
  endtask

  logic [31:0] exp2 [4];
  logic [31:0] exp4 [6];
  logic [31:0] prev_d;
  logic        prev_v, prev_r;
  int          h0, d0, beats;

  initial begin
    exp2 = '{32'h0001, 32'h0003, 32'h0002, 32'h0001};
    exp4 = '{32'h0001, 32'h0003, 32'h0002, 32'h0001, 32'h0003, 32'h0002};
    ARESET_n = 1'b0;
    start = 1'b0; frame_len = '0; seed_load = 1'b0; seed = '0; pause = 1'b0;
    axis_bus.TREADY = 1'b1;
    tick(); tick();
    check("rst_tvalid", 32'(axis_bus.TVALID), 0);
    check("rst_tlast",  32'(axis_bus.TLAST), 0);
    check("rst_tdata",  axis_bus.TDATA, 0);
    check("rst_busy",   32'(busy), 0);
    check("rst_done",   32'(done), 0);
    ARESET_n = 1'b1;
    tick();

    // Single-beat frame, seed and start in the same cycle
    launch(16'd1, 1'b1, 32'h1);
    check("t1_tvalid", 32'(axis_bus.TVALID), 1);
    check("t1_tdata",  axis_bus.TDATA, 32'h0000_0001);
    check("t1_tlast",  32'(axis_bus.TLAST), 1);
    check("t1_busy",   32'(busy), 1);
    tick();
    check("t1_done",   32'(done), 1);
    check("t1_busy_fin", 32'(busy), 0);
    check("t1_tvalid_fin", 32'(axis_bus.TVALID), 0);
`ifdef AXIS_GOLDEN_MAX_EN
    check("t1_gvalid", 32'(golden_valid), 1);
    check("t1_gmax", 32'(golden_max), 32'h1);
`endif
    tick();
    check("t1_done_pulse", 32'(done), 0);
    // LFSR should now hold 8020_0003
    launch(16'd1, 1'b0, 32'h0);
    check("t1b_tdata", axis_bus.TDATA, 32'h0000_0003);
    tick(); tick();

    // Four back-to-back beats
    launch(16'd4, 1'b1, 32'h1);
    for (int i = 0; i < 4; i++) begin
      check("t2_tvalid", 32'(axis_bus.TVALID), 1);
      check("t2_tdata", axis_bus.TDATA, exp2[i]);
      check("t2_tlast", 32'(axis_bus.TLAST), (i == 3) ? 1 : 0);
      tick();
    end
    check("t2_done", 32'(done), 1);
`ifdef AXIS_GOLDEN_MAX_EN
    check("t2_gmax", 32'(golden_max), 32'h3);
`endif
    tick();

    // Zero-length start is ignored
    launch(16'd0, 1'b0, 32'h0);
    check("t5_len0_busy", 32'(busy), 0);
    check("t5_len0_tvalid", 32'(axis_bus.TVALID), 0);
    tick();
    check("t5_len0_busy2", 32'(busy), 0);

    // Backpressure on beat 2; start/seed_load/pause during the stall
    launch(16'd3, 1'b1, 32'h1);
    h0 = hs_cnt;
    check("t3_b0", axis_bus.TDATA, 32'h1);
    tick();
    check("t3_b1", axis_bus.TDATA, 32'h3);
    axis_bus.TREADY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pause = 1'b1; start = 1'b1; frame_len = 16'd7;
      seed_load = 1'b1; seed = 32'h1234_5678;
      tick();
      check("t3_stall_v", 32'(axis_bus.TVALID), 1);
      check("t3_stall_d", axis_bus.TDATA, 32'h3);
      check("t3_stall_l", 32'(axis_bus.TLAST), 0);
      check("t3_stall_busy", 32'(busy), 1);
    end
    start = 1'b0; seed_load = 1'b0; pause = 1'b0;
    axis_bus.TREADY = 1'b1;
    tick();
    check("t3_b2", axis_bus.TDATA, 32'h2);
    check("t3_b2_last", 32'(axis_bus.TLAST), 1);
    tick();
    check("t3_done", 32'(done), 1);
    check("t3_hs", 32'(hs_cnt - h0), 3);
`ifdef AXIS_GOLDEN_MAX_EN
    check("t3_gmax", 32'(golden_max), 32'h3);
`endif
    tick();
    launch(16'd2, 1'b0, 32'h0);
    check("t3b_b0", axis_bus.TDATA, 32'h1);
    tick();
    check("t3b_b1", axis_bus.TDATA, 32'h3);
    tick(); tick();

    // Pause toggling with intermittent TREADY on a 6-beat frame
    d0 = done_cnt;
    launch(16'd6, 1'b1, 32'h1);
    beats = 0; prev_v = 1'b0; prev_r = 1'b1; prev_d = '0;
    for (int c = 0; c < 60; c++) begin
      if (done) break;
      if (prev_v && !prev_r) begin
        check("t4_hold_v", 32'(axis_bus.TVALID), 1);
        check("t4_hold_d", axis_bus.TDATA, prev_d);
      end
      pause = c[0];
      axis_bus.TREADY = (c % 3) != 2;
      if (axis_bus.TVALID && axis_bus.TREADY) begin
        if (beats < 6) begin
          check("t4_data", axis_bus.TDATA, exp4[beats]);
          check("t4_last", 32'(axis_bus.TLAST), (beats == 5) ? 1 : 0);
        end
        beats++;
      end
      prev_v = axis_bus.TVALID; prev_r = axis_bus.TREADY; prev_d = axis_bus.TDATA;
      tick();
    end
    check("t4_done_seen", 32'(done), 1);
    check("t4_beats", 32'(beats), 6);
    pause = 1'b0; axis_bus.TREADY = 1'b1;
    tick();
    check("t4_done_once", 32'(done_cnt - d0), 1);
    tick();

    // Asynchronous reset after 2 of 5 beats
    launch(16'd5, 1'b1, 32'h1);
    tick(); tick();
    check("t6_pre_b2", axis_bus.TDATA, 32'h2);
    d0 = done_cnt;
    #2 ARESET_n = 1'b0;
    #1;
    check("t6_rst_tvalid", 32'(axis_bus.TVALID), 0);
    check("t6_rst_tdata", axis_bus.TDATA, 0);
    check("t6_rst_tlast", 32'(axis_bus.TLAST), 0);
    check("t6_rst_busy", 32'(busy), 0);
`ifdef AXIS_GOLDEN_MAX_EN
    check("t6_rst_gmax", 32'(golden_max), 0);
    check("t6_rst_gvalid", 32'(golden_valid), 0);
`endif
    @(posedge ACLK); @(posedge ACLK);
    #3 ARESET_n = 1'b1;
    tick(); tick();
    check("t6_no_done", 32'(done_cnt - d0), 0);
    check("t6_idle_tvalid", 32'(axis_bus.TVALID), 0);
    launch(16'd1, 1'b0, 32'h0);
    check("t6_restart_d", axis_bus.TDATA, 32'h1);
    tick(); tick();

    // Distinct seed for golden max, then zero seed falls back to 1
    launch(16'd2, 1'b1, 32'h0000_FFFF);
    check("t7_b0", axis_bus.TDATA, 32'h0000_FFFF);
    tick();
    check("t7_b1", axis_bus.TDATA, 32'h0000_7FFC);
    tick();
    check("t7_done", 32'(done), 1);
`ifdef AXIS_GOLDEN_MAX_EN
    check("t7_gmax", 32'(golden_max), 32'hFFFF);
`endif
    tick();
    launch(16'd1, 1'b1, 32'h0);
    check("t7_seed0", axis_bus.TDATA, 32'h1);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
